riscv_lsu: RTL

- Parametrised load/store unit sitting between core execute stage and data memory; successor to the fixed 32-bit, zero-wait-state load/store path.
- Generalised to XLEN 32/64 and to byte-lane alignment (offset-aware byte enables and lane shifting).
- Adds a valid/ready request handshake with the core, a req/gnt/rvalid memory protocol with wait states, misalignment/illegal-size detection and a bus timeout.
- Core stalls on req_ready_o low; one transaction in flight at a time.

---
 rtl/riscv_lsu_pkg.sv | 42 ++++
 rtl/riscv_lsu_if.sv | 54 +++++
 rtl/riscv_lsu_align.sv | 62 ++++++
 rtl/riscv_lsu.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// rtl/riscv_lsu_pkg.sv - shared types and helpers for the load/store unit
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_SIZE     = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } lsu_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // A doubleword access cannot be carried on a 32-bit bus
  function automatic logic size_illegal(input lsu_size_e sz, input int xlen);
    return (sz == SZ_D) && (xlen == 32);
  endfunction

  // Natural alignment: the low log2(bytes) address bits must be zero
  function automatic logic misaligned(input lsu_size_e sz, input logic [2:0] addr_lo);
    logic mis;
    case (sz)
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = |addr_lo[1:0];
      SZ_D:    mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// rtl/riscv_lsu_if.sv - core request/response and data memory bus bundle
interface riscv_lsu_if #(
  parameter int XLEN = 32
);

  // core request
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [XLEN-1:0]   req_addr_i;
  logic [XLEN-1:0]   req_wdata_i;
  logic [4:0]        req_rd_i;

  // core response
  logic              resp_valid_o;
  logic [XLEN-1:0]   resp_rdata_o;
  logic [4:0]        resp_rd_o;
  logic [1:0]        resp_err_o;

  // data memory
  logic              mem_req_o;
  logic              mem_we_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;

  logic              busy_o;

  // LSU side
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, req_rd_i,
    output req_ready_o,
    output resp_valid_o, resp_rdata_o, resp_rd_o, resp_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output busy_o
  );

  // core + memory side
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, req_rd_i,
    input  req_ready_o,
    input  resp_valid_o, resp_rdata_o, resp_rd_o, resp_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  busy_o
  );

endinterface

// File: rtl/riscv_lsu_align.sv
// rtl/riscv_lsu_align.sv - byte-lane enables, store shift and load extract/extend
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  lsu_size_e                 size_i,
  input  logic                      unsigned_i,
  input  logic [$clog2(XLEN/8)-1:0] offset_i,
  input  logic [XLEN-1:0]           wdata_i,
  input  logic [XLEN-1:0]           rdata_i,
  output logic [XLEN/8-1:0]         be_o,
  output logic [XLEN-1:0]           wdata_o,
  output logic [XLEN-1:0]           rdata_o
);

  localparam int BE_W = XLEN / 8;

  logic [7:0]      mask8;
  logic [BE_W-1:0] mask;
  logic [XLEN-1:0] rshift;
  logic [XLEN-1:0] keep;
  logic            sign;

  // Size mask moved up to the addressed byte lane; store data follows it
  always_comb begin
    case (size_i)
      SZ_B:    mask8 = 8'h01;
      SZ_H:    mask8 = 8'h03;
      SZ_W:    mask8 = 8'h0F;
      default: mask8 = 8'hFF;
    endcase
    mask    = mask8[BE_W-1:0];
    be_o    = mask << offset_i;
    wdata_o = wdata_i << {offset_i, 3'b000};
  end

  // Bring the addressed lane down to bit 0, keep the access width, fill the rest
  always_comb begin
    rshift = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      SZ_B: begin
        keep = XLEN'(8'hFF);
        sign = rshift[7];
      end
      SZ_H: begin
        keep = XLEN'(16'hFFFF);
        sign = rshift[15];
      end
      SZ_W: begin
        keep = XLEN'(32'hFFFF_FFFF);
        sign = rshift[31];
      end
      default: begin
        keep = '1;
        sign = 1'b0;
      end
    endcase
    rdata_o = (rshift & keep) | (~keep & {XLEN{sign & ~unsigned_i}});
  end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit between execute stage and data memory
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic        clk_i,
  input logic        rst_i,
  riscv_lsu_if.slave bus
);

  localparam int OFF_W = $clog2(XLEN / 8);
  // keep the counter at least one bit wide when the timeout is disabled
  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  lsu_size_e       size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [4:0]      rd_q, rd_d;
  lsu_err_e        err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  lsu_size_e         req_size;
  lsu_err_e          req_err;
  logic              accept;
  logic              done;
  logic              tmo_hit;
  logic [XLEN/8-1:0] lane_be;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN-1:0]   load_data;

  riscv_lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .offset_i   (addr_q[OFF_W-1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (bus.mem_rdata_i),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (load_data)
  );

  // Request decode, completion and timeout conditions
  always_comb begin
    req_size = lsu_size_e'(bus.req_size_i);
    accept   = bus.req_valid_i && (state_q == ST_IDLE);
    if (size_illegal(req_size, XLEN)) begin
      req_err = ERR_SIZE;
    end else if (misaligned(req_size, bus.req_addr_i[2:0])) begin
      req_err = ERR_MISALIGN;
    end else begin
      req_err = ERR_NONE;
    end
    // rvalid together with gnt completes straight out of REQ
    done    = bus.mem_rvalid_i &&
              ((state_q == ST_WAIT) || ((state_q == ST_REQ) && bus.mem_gnt_i));
    // counter reaches TIMEOUT_CYCLES on the edge that leaves REQ/WAIT
    tmo_hit = TMO_EN && (cnt_q == TMO_LAST) &&
              ((state_q == ST_REQ) || (state_q == ST_WAIT));
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; completion beats timeout, timeout beats a bare grant
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (req_err != ERR_NONE) ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (done || tmo_hit) begin
          state_d = ST_RESP;
        end else if (bus.mem_gnt_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done || tmo_hit) begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the request on accept and the response data on completion
  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = bus.req_we_i;
          size_d  = req_size;
          uns_d   = bus.req_unsigned_i;
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          rd_d    = bus.req_rd_i;
          err_d   = req_err;
          cnt_d   = '0;
          if (req_err != ERR_NONE) begin
            rdata_d = '0;
          end
        end
      end
      ST_REQ, ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (done) begin
          rdata_d = we_q ? '0 : load_data;
        end else if (tmo_hit) begin
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; memory fields only driven while requesting
  always_comb begin
    bus.req_ready_o  = (state_q == ST_IDLE);
    bus.busy_o       = (state_q != ST_IDLE);
    bus.resp_valid_o = (state_q == ST_RESP);
    bus.resp_rdata_o = rdata_q;
    bus.resp_rd_o    = rd_q;
    bus.resp_err_o   = err_q;
    bus.mem_req_o    = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_be_o     = '0;
    bus.mem_wdata_o  = '0;
    if (state_q == ST_REQ) begin
      bus.mem_req_o                = 1'b1;
      bus.mem_we_o                 = we_q;
      bus.mem_addr_o               = addr_q;
      bus.mem_addr_o[OFF_W-1:0]    = '0;
      bus.mem_be_o                 = lane_be;
      bus.mem_wdata_o              = we_q ? lane_wdata : '0;
    end
  end

endmodule
